// File: rtl/pixel_port_arbiter_if.sv
// Bundle of the channel-side and pixel-source-side signals of pixel_port_arbiter.
//   slave  : arbiter view (requests and pixel responses in; grants, responses and status out)
//   master : requester/source view (the opposite directions)
//   ch_req/ch_addr/ch_grant/ch_valid/ch_err/ch_data : per-channel request/response bus
//   addr_pixel/request_pixel/pixel/pixel_avail      : shared external pixel interface
//   outstanding/spurious                            : status
interface pixel_port_arbiter_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_grant;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_err;
  logic [DATA_W-1:0]        ch_data;
  logic [ADDR_W-1:0]        addr_pixel;
  logic                     request_pixel;
  logic [DATA_W-1:0]        pixel;
  logic                     pixel_avail;
  logic [CNT_W-1:0]         outstanding;
  logic                     spurious;

  modport slave (
    input  ch_req, ch_addr, pixel, pixel_avail,
    output ch_grant, ch_valid, ch_err, ch_data, addr_pixel, request_pixel,
           outstanding, spurious
  );

  modport master (
    output ch_req, ch_addr, pixel, pixel_avail,
    input  ch_grant, ch_valid, ch_err, ch_data, addr_pixel, request_pixel,
           outstanding, spurious
  );
endinterface

// File: rtl/pixel_port_arbiter.sv
// Shares one external pixel port among NUM_CH requesters. Fixed-priority or
// round-robin arbitration, up to MAX_OUTST in-order outstanding requests tracked
// in a tag FIFO, and a response timeout that retires a lost head request.
//   clk_i : clock
//   res_i : asynchronous active-high reset
//   bus   : pixel_port_arbiter_if.slave (channel requests/responses, pixel port, status)
module pixel_port_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                 clk_i,
  input  logic                 res_i,
  pixel_port_arbiter_if.slave  bus
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
  localparam int unsigned TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CH_W-1:0]   tag_q [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [NUM_CH-1:0] grant_q, grant_d, valid_q, valid_d, err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d, spur_q, spur_d;

  logic [NUM_CH-1:0] eligible;
  logic [CH_W-1:0]   win, idx, head;
  logic              found, issue, pop_ok, to_fire, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Arbitration, FIFO bookkeeping, timeout and next output values
  always_comb begin
    eligible = bus.ch_req & ~grant_q;   // channel granted last edge sits out one cycle
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE == 1) ? CH_W'((32'(rr_ptr_q) + k) % NUM_CH) : CH_W'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    // Full FIFO blocks issue even if a pop happens in the same cycle
    issue   = found && (cnt_q < CNT_W'(MAX_OUTST));
    head    = tag_q[rd_ptr_q];
    pop_ok  = bus.pixel_avail && (cnt_q != '0);
    // A real response in the timeout cycle takes precedence over the error
    to_fire = (TIMEOUT != 0) && (cnt_q != '0) && !bus.pixel_avail &&
              (to_cnt_q == TO_W'(TIMEOUT));
    pop     = pop_ok || to_fire;

    grant_d  = '0;
    valid_d  = '0;
    err_d    = '0;
    req_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    spur_d   = spur_q | (bus.pixel_avail && (cnt_q == '0));
    wr_ptr_d = issue ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(issue) - CNT_W'(pop);

    if (issue) begin
      req_d   = 1'b1;
      addr_d  = bus.ch_addr[32'(win) * ADDR_W +: ADDR_W];
      grant_d = NUM_CH'(1) << win;
      if (ARB_MODE == 1) begin
        rr_ptr_d = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
      end
    end

    if (pop_ok) begin
      valid_d = NUM_CH'(1) << head;
      data_d  = bus.pixel;
    end else if (to_fire) begin
      err_d  = NUM_CH'(1) << head;
      data_d = '0;
    end

    // Saturating wait counter, only live while something is outstanding
    if ((TIMEOUT == 0) || bus.pixel_avail || (cnt_q == '0) || to_fire) begin
      to_cnt_d = '0;
    end else if (to_cnt_q < TO_W'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      for (int unsigned i = 0; i < MAX_OUTST; i++) tag_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      to_cnt_q <= '0;
      grant_q  <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      req_q    <= 1'b0;
      spur_q   <= 1'b0;
    end else begin
      if (issue) tag_q[wr_ptr_q] <= win;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      to_cnt_q <= to_cnt_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      spur_q   <= spur_d;
    end
  end

  assign bus.ch_grant      = grant_q;
  assign bus.ch_valid      = valid_q;
  assign bus.ch_err        = err_q;
  assign bus.ch_data       = data_q;
  assign bus.addr_pixel    = addr_q;
  assign bus.request_pixel = req_q;
  assign bus.outstanding   = cnt_q;
  assign bus.spurious      = spur_q;

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Directed bench for pixel_port_arbiter: three instances cover fixed priority
// (no timeout), round robin (no timeout) and fixed priority with TIMEOUT=8.
module tb_pixel_port_arbiter;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pixel_port_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) if_fp ();
  pixel_port_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) if_rr ();
  pixel_port_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) if_to ();

  pixel_port_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4),
                       .ARB_MODE(0), .TIMEOUT(0))
    dut_fp (.clk_i(clk), .res_i(res), .bus(if_fp));
  pixel_port_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4),
                       .ARB_MODE(1), .TIMEOUT(0))
    dut_rr (.clk_i(clk), .res_i(res), .bus(if_rr));
  pixel_port_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4),
                       .ARB_MODE(0), .TIMEOUT(8))
    dut_to (.clk_i(clk), .res_i(res), .bus(if_to));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int heads[4] = '{1, 2, 3, 0};
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    if_fp.ch_req = '0; if_fp.ch_addr = '0; if_fp.pixel = '0; if_fp.pixel_avail = 1'b0;
    if_rr.ch_req = '0; if_rr.ch_addr = '0; if_rr.pixel = '0; if_rr.pixel_avail = 1'b0;
    if_to.ch_req = '0; if_to.ch_addr = '0; if_to.pixel = '0; if_to.pixel_avail = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(if_fp.ch_grant), 64'h0);
    chk("rst_valid", 64'(if_fp.ch_valid), 64'h0);
    chk("rst_err", 64'(if_fp.ch_err), 64'h0);
    chk("rst_data", 64'(if_fp.ch_data), 64'h0);
    chk("rst_addr", 64'(if_fp.addr_pixel), 64'h0);
    chk("rst_reqpix", 64'(if_fp.request_pixel), 64'h0);
    chk("rst_outst", 64'(if_fp.outstanding), 64'h0);
    chk("rst_spur", 64'(if_fp.spurious), 64'h0);
    res = 1'b0;

    // Fixed priority: ch1 and ch3 together
    if_fp.ch_addr[1*32 +: 32] = 32'h100;
    if_fp.ch_addr[3*32 +: 32] = 32'h300;
    if_fp.ch_req = 4'b1010;
    step();
    chk("fp_grant1", 64'(if_fp.ch_grant), 64'b0010);
    chk("fp_reqpix1", 64'(if_fp.request_pixel), 64'h1);
    chk("fp_addr1", 64'(if_fp.addr_pixel), 64'h100);
    chk("fp_outst1", 64'(if_fp.outstanding), 64'h1);
    if_fp.ch_req = 4'b1000;
    step();
    chk("fp_grant3", 64'(if_fp.ch_grant), 64'b1000);
    chk("fp_addr3", 64'(if_fp.addr_pixel), 64'h300);
    chk("fp_outst2", 64'(if_fp.outstanding), 64'h2);
    if_fp.ch_req = 4'b0000;
    if_fp.pixel = 32'hAA;
    if_fp.pixel_avail = 1'b1;
    step();
    chk("fp_valid1", 64'(if_fp.ch_valid), 64'b0010);
    chk("fp_data1", 64'(if_fp.ch_data), 64'hAA);
    chk("fp_grant_idle", 64'(if_fp.ch_grant), 64'h0);
    chk("fp_reqpix_idle", 64'(if_fp.request_pixel), 64'h0);
    chk("fp_addr_hold", 64'(if_fp.addr_pixel), 64'h300);
    if_fp.pixel = 32'hBB;
    step();
    chk("fp_valid3", 64'(if_fp.ch_valid), 64'b1000);
    chk("fp_data3", 64'(if_fp.ch_data), 64'hBB);
    chk("fp_outst0", 64'(if_fp.outstanding), 64'h0);
    if_fp.pixel_avail = 1'b0;
    step();
    chk("fp_valid_idle", 64'(if_fp.ch_valid), 64'h0);
    chk("fp_data_hold", 64'(if_fp.ch_data), 64'hBB);

    // Full FIFO
    for (int i = 0; i < 4; i++) if_fp.ch_addr[i*32 +: 32] = 32'h1000 + 32'(i);
    if_fp.ch_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("full_fill_grant", 64'(if_fp.ch_grant), 64'(1) << i);
      if_fp.ch_req[i] = 1'b0;
    end
    chk("full_outst4", 64'(if_fp.outstanding), 64'h4);
    if_fp.ch_req = 4'b0001;
    step();
    chk("full_blocked_grant", 64'(if_fp.ch_grant), 64'h0);
    chk("full_blocked_reqpix", 64'(if_fp.request_pixel), 64'h0);
    chk("full_blocked_outst", 64'(if_fp.outstanding), 64'h4);
    if_fp.pixel = 32'h11;
    if_fp.pixel_avail = 1'b1;
    step();
    chk("full_pop_valid", 64'(if_fp.ch_valid), 64'b0001);
    chk("full_pop_grant", 64'(if_fp.ch_grant), 64'h0);
    chk("full_pop_outst", 64'(if_fp.outstanding), 64'h3);
    if_fp.pixel_avail = 1'b0;
    step();
    chk("full_late_grant", 64'(if_fp.ch_grant), 64'b0001);
    chk("full_late_addr", 64'(if_fp.addr_pixel), 64'h1000);
    chk("full_late_outst", 64'(if_fp.outstanding), 64'h4);
    if_fp.ch_req = 4'b0000;
    if_fp.pixel_avail = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_fp.pixel = 32'h20 + 32'(i);
      step();
      chk("full_drain_valid", 64'(if_fp.ch_valid), 64'(1) << heads[i]);
      chk("full_drain_data", 64'(if_fp.ch_data), 64'h20 + 64'(i));
    end
    if_fp.pixel_avail = 1'b0;
    chk("full_drain_outst", 64'(if_fp.outstanding), 64'h0);

    // Round robin, all channels requesting, answered one cycle later
    for (int i = 0; i < 4; i++) if_rr.ch_addr[i*32 +: 32] = 32'h400 + 32'(i);
    if_rr.ch_req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_grant", 64'(if_rr.ch_grant), 64'(1) << rr_exp[k]);
      chk("rr_addr", 64'(if_rr.addr_pixel), 64'h400 + 64'(rr_exp[k]));
      if (k > 0) begin
        chk("rr_valid", 64'(if_rr.ch_valid), 64'(1) << rr_exp[k-1]);
        chk("rr_data", 64'(if_rr.ch_data), 64'h50 + 64'(k - 1));
      end
      chk("rr_outst", 64'(if_rr.outstanding), 64'h1);
      if_rr.pixel = 32'h50 + 32'(k);
      if_rr.pixel_avail = 1'b1;
    end
    if_rr.ch_req = 4'b0000;
    step();
    chk("rr_last_valid", 64'(if_rr.ch_valid), 64'b0010);
    chk("rr_last_data", 64'(if_rr.ch_data), 64'h55);
    chk("rr_last_outst", 64'(if_rr.outstanding), 64'h0);
    chk("rr_last_grant", 64'(if_rr.ch_grant), 64'h0);
    if_rr.pixel_avail = 1'b0;

    // Timeout: a normal transaction first so ch_data is non-zero
    if_to.ch_addr[2*32 +: 32] = 32'h200;
    if_to.ch_req = 4'b0100;
    step();
    chk("to_grant_a", 64'(if_to.ch_grant), 64'b0100);
    if_to.ch_req = 4'b0000;
    if_to.pixel = 32'hCC;
    if_to.pixel_avail = 1'b1;
    step();
    chk("to_normal_valid", 64'(if_to.ch_valid), 64'b0100);
    chk("to_normal_data", 64'(if_to.ch_data), 64'hCC);
    if_to.pixel_avail = 1'b0;
    if_to.ch_req = 4'b0100;
    step();
    chk("to_grant_b", 64'(if_to.ch_grant), 64'b0100);
    if_to.ch_req = 4'b0000;
    repeat (8) step();
    chk("to_wait_err", 64'(if_to.ch_err), 64'h0);
    chk("to_wait_outst", 64'(if_to.outstanding), 64'h1);
    step();
    chk("to_err", 64'(if_to.ch_err), 64'b0100);
    chk("to_err_data", 64'(if_to.ch_data), 64'h0);
    chk("to_err_outst", 64'(if_to.outstanding), 64'h0);
    chk("to_err_valid", 64'(if_to.ch_valid), 64'h0);
    step();
    chk("to_err_pulse", 64'(if_to.ch_err), 64'h0);
    if_to.ch_req = 4'b0100;
    step();
    chk("to_grant_c", 64'(if_to.ch_grant), 64'b0100);
    if_to.ch_req = 4'b0000;
    repeat (8) step();
    if_to.pixel = 32'hDD;
    if_to.pixel_avail = 1'b1;
    step();
    chk("to_race_valid", 64'(if_to.ch_valid), 64'b0100);
    chk("to_race_err", 64'(if_to.ch_err), 64'h0);
    chk("to_race_data", 64'(if_to.ch_data), 64'hDD);
    chk("to_race_outst", 64'(if_to.outstanding), 64'h0);
    if_to.pixel_avail = 1'b0;

    // Spurious response with nothing outstanding
    if_fp.pixel = 32'hEE;
    if_fp.pixel_avail = 1'b1;
    step();
    chk("spur_set", 64'(if_fp.spurious), 64'h1);
    chk("spur_no_valid", 64'(if_fp.ch_valid), 64'h0);
    chk("spur_data_hold", 64'(if_fp.ch_data), 64'h23);
    if_fp.pixel_avail = 1'b0;
    repeat (3) step();
    chk("spur_sticky", 64'(if_fp.spurious), 64'h1);

    // Asynchronous reset with three requests in flight
    if_fp.ch_req = 4'b0111;
    step();
    if_fp.ch_req = 4'b0110;
    step();
    if_fp.ch_req = 4'b0100;
    step();
    if_fp.ch_req = 4'b0000;
    chk("ares_outst_pre", 64'(if_fp.outstanding), 64'h3);
    chk("ares_grant_pre", 64'(if_fp.ch_grant), 64'b0100);
    #2;
    res = 1'b1;
    #1;
    chk("ares_grant", 64'(if_fp.ch_grant), 64'h0);
    chk("ares_reqpix", 64'(if_fp.request_pixel), 64'h0);
    chk("ares_addr", 64'(if_fp.addr_pixel), 64'h0);
    chk("ares_data", 64'(if_fp.ch_data), 64'h0);
    chk("ares_outst", 64'(if_fp.outstanding), 64'h0);
    chk("ares_spur", 64'(if_fp.spurious), 64'h0);
    chk("ares_valid", 64'(if_fp.ch_valid), 64'h0);
    chk("ares_err", 64'(if_fp.ch_err), 64'h0);
    #1;
    res = 1'b0;
    step();
    if_fp.pixel = 32'h77;
    if_fp.pixel_avail = 1'b1;
    step();
    chk("post_res_spur", 64'(if_fp.spurious), 64'h1);
    chk("post_res_valid", 64'(if_fp.ch_valid), 64'h0);
    chk("post_res_outst", 64'(if_fp.outstanding), 64'h0);
    step();
    chk("post_res_valid2", 64'(if_fp.ch_valid), 64'h0);
    if_fp.pixel_avail = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_port_arbiter.md
Name: pixel_port_arbiter

Overview:
- Parametrised successor to the single-requester pixel port on the memory-controller side of the NoC system.
- Shares one external pixel interface (addr_pixel/request_pixel out, pixel/pixel_avail in) among NUM_CH requesters, which are nodes or memory-controller agents.
- Supports selectable fixed-priority or round-robin arbitration and up to MAX_OUTST in-order outstanding requests.
- A response timeout retires lost requests with an error pulse to the originating channel.

Parameters:
NUM_CH, 4, number of requesting channels (2..16)
ADDR_W, 32, pixel address width
DATA_W, 32, pixel data width
MAX_OUTST, 4, depth of in-order outstanding-tag FIFO (power of two, 1..16)
ARB_MODE, 0, 0 = fixed priority (ch0 highest), 1 = round robin
TIMEOUT, 1023, cycles without pixel_avail before head request is retired; 0 disables

Ports:
clk  in  1  system clock
res  in  1  reset
ch_req  in  NUM_CH  per-channel request level
ch_addr  in  NUM_CH*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W]
ch_grant  out  NUM_CH  one-hot, 1-cycle pulse: request accepted
ch_valid  out  NUM_CH  one-hot, 1-cycle pulse: response for channel on ch_data
ch_err  out  NUM_CH  one-hot, 1-cycle pulse: head request timed out
ch_data  out  DATA_W  response data, shared by all channels
addr_pixel  out  ADDR_W  address to external pixel source
request_pixel  out  1  1-cycle request strobe
pixel  in  DATA_W  external response data
pixel_avail  in  1  external response strobe, 1 cycle per response
outstanding  out  $clog2(MAX_OUTST)+1  current outstanding count
spurious  out  1  sticky: pixel_avail seen with nothing outstanding

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset, applied at any time:
  - All outputs are 0.
  - Tag FIFO empty, RR pointer = 0, timeout counter = 0.
  - In-flight requests are discarded; no completions follow reset.
- Issue condition in cycle t: at least one eligible ch_req AND outstanding < MAX_OUTST.
- Eligibility:
  - A channel granted at the edge ending t-1 is masked during t.
  - Requesters must drop or refresh ch_req when they see ch_grant; one request is issued per grant.
- Winner selection:
  - ARB_MODE 0: lowest index wins.
  - ARB_MODE 1: first eligible index at or after the RR pointer, wrapping modulo NUM_CH. On issue, the pointer becomes winner+1, wrapping at NUM_CH.
- At the edge ending t, for the winner w:
  - request_pixel <= 1, addr_pixel <= ch_addr[w], ch_grant[w] <= 1.
  - w is pushed into the tag FIFO.
  - request_pixel and ch_grant are single-cycle pulses.
  - addr_pixel holds its value until the next issue.
- Response: pixel_avail high in cycle t with FIFO non-empty:
  - Head h is popped.
  - At the edge: ch_valid[h] <= 1, ch_data <= pixel.
  - Latency 1 cycle.
  - ch_data holds until the next completion.
- Same-cycle push and pop are both performed; outstanding is unchanged.
- Full FIFO: issue is blocked. A pop in the same cycle does not unblock it; the earliest issue is the next cycle.
- pixel_avail with FIFO empty: ignored, and spurious <= 1. spurious is cleared only by reset.
- Timeout (TIMEOUT > 0):
  - The counter increments each cycle while outstanding > 0 and pixel_avail = 0.
  - It clears on pixel_avail or when outstanding = 0.
  - When the counter reaches TIMEOUT: the head is popped, ch_err[head] <= 1, ch_data <= 0, and the counter clears.
  - If pixel_avail arrives in the same cycle as the timeout, the normal response wins and there is no error.
- Ordering: responses are strictly in issue order. The external source must answer in order.
- Counter widths: outstanding never exceeds MAX_OUTST. The timeout counter saturates at TIMEOUT and never wraps.

Test Plan:
- Fixed priority, ARB_MODE=0: ch1 and ch3 request in the same cycle with addr 0x100 and 0x300. ch1 is granted first; the next eligible cycle grants ch3. addr_pixel sequence is 0x100 then 0x300. pixel_avail responses 0xAA then 0xBB produce ch_valid[1] with 0xAA, then ch_valid[3] with 0xBB.
- Round robin, ARB_MODE=1: all 4 channels hold ch_req continuously and every request is answered one cycle later. Grant order is 0,1,2,3,0,1. No channel is granted in two consecutive cycles.
- Full FIFO, MAX_OUTST=4: 4 issues with no responses. outstanding=4, and a 5th ch_req sees no grant. One pixel_avail brings outstanding to 3, and the 5th request is granted the following cycle.
- Timeout, TIMEOUT=8: one request from ch2 with no response. After 8 cycles, a ch_err[2] pulse with ch_data=0 and outstanding=0. A pixel_avail arriving on the same cycle the counter hits 8 gives ch_valid[2] instead.
- pixel_avail with nothing outstanding: spurious=1 and no ch_valid. spurious stays 1 until res.
- Reset while 3 requests are outstanding: all outputs are 0 immediately, asynchronously. Later pixel_avail pulses set spurious and produce no ch_valid.
